mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the E stage of the five-stage pipelined MIPS core, sitting beside the ALU and fed from the same forwarded operands `srcA`/`srcB`. It executes `mult`, `multu`, `div`, `divu` as multi-cycle operations into private HI/LO registers. It handles `mthi`/`mtlo` writes in a single cycle and serves `mfhi`/`mflo` reads combinationally. It exports `busy` so the hazard unit can stall any HI/LO-touching instruction in D while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: execution cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: execution cycles for `div`/`divu`.

- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `mdOp`  in  4  operation code: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, `MD_MFHI`, `MD_MFLO`, `MD_NONE`.
- `start`  in  1  strobe qualifying a write-type `mdOp` (mult/div/mthi/mtlo) this cycle.
- `srcA`  in  32  rs operand, forwarded.
- `srcB`  in  32  rt operand, forwarded.
- `busy`  out  1  high while a mult/div is executing.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mdRes`  out  32  read result: `hi` for `MD_MFHI`, `lo` for `MD_MFLO`, else 0; combinational.

## Operation
- State machine with two states:
  - IDLE (`busy`=0).
  - RUN (`busy`=1): holds `cnt` and pending `hiNext`/`loNext`.
- IDLE with `start`=1:
  - `MD_MULT`: signed 64-bit product latched into `{hiNext,loNext}`; `cnt`←`MULT_CYCLES`; enter RUN.
  - `MD_MULTU`: unsigned 64-bit product latched into `{hiNext,loNext}`; `cnt`←`MULT_CYCLES`; enter RUN.
  - `MD_DIV` / `MD_DIVU`: `loNext`←quotient, `hiNext`←remainder; `cnt`←`DIV_CYCLES`; enter RUN.
  - `MD_MTHI`: `hi`←`srcA` at this edge; stay IDLE.
  - `MD_MTLO`: `lo`←`srcA` at this edge; stay IDLE.
  - Any other `mdOp`: no state change.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed divide `0x80000000 / 0xFFFFFFFF`: `lo`=0x80000000, `hi`=0.
- Divide by zero (`srcB`=0): operation runs for the full `DIV_CYCLES` and `busy` behaves normally, but `hi`/`lo` are left unchanged at completion.
- RUN: `cnt` decrements each edge. On the edge where `cnt`==1, `hi`←`hiNext`, `lo`←`loNext`, and the state returns to IDLE.
- `start` while in RUN is ignored for all ops, including mthi/mtlo. The hazard unit guarantees this never happens; the bench checks that it is ignored.
- Operands are captured at the start edge. Later changes on `srcA`/`srcB` have no effect on a running operation.
- Reset (`reset`=0 at an edge): `hi`=0, `lo`=0, `busy`=0, `cnt`=0, IDLE. A reset mid-RUN aborts the operation and discards the pending result.

## Timing
- `start` sampled at edge E0. `busy` is high from after E0 through edge E0+N, where N=`MULT_CYCLES` or `DIV_CYCLES`; `busy`=N cycles exactly.
- `hi`/`lo` take the new values at E0+N, the same edge `busy` falls. An `mfhi`/`mflo` in E in the first cycle with `busy`=0 reads the new value.
- Back-to-back: `start` in the first cycle with `busy`=0 is accepted, giving zero idle gap.
- mthi/mtlo: visible on `hi`/`lo` one edge after `start`.
- `mdRes`: zero-cycle combinational path from `hi`/`lo`/`mdOp`.

## Structure
- `macro.v` holds:
  - the `MD_*` opcode defines (4-bit, with `MD_NONE`=0);
  - `MD_MULT_CYCLES`=5 and `MD_DIV_CYCLES`=10, used as parameter defaults.
- No sub-module. The 64-bit product and the quotient/remainder are computed behaviourally in one combinational block inside `mdu`.
- The stall condition (`busy | start`) combined with a D-stage HI/LO op lives in the hazard unit, not here.

## Test plan
- Reset: hold `reset`=0 for 2 cycles after arbitrary activity -> `hi`=`lo`=0 and `busy`=0.
- `MD_MULT`, `srcA`=0xFFFFFFFE (−2), `srcB`=3 -> `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA. The same operands with `MD_MULTU` -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- `MD_DIV`, `srcA`=−7, `srcB`=2 -> `busy` high for 10 cycles, then `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Then `MD_DIVU`, 7/0 -> `busy` high for 10 cycles, with `hi`/`lo` unchanged afterwards.
- `MD_MTHI` with `srcA`=0x12345678 in IDLE -> `hi`=0x12345678 after one edge. The same `start` issued mid-RUN -> ignored, and the pending result still lands.
- `reset` asserted at cycle 3 of a div -> `busy`=0 and `hi`=`lo`=0 next edge. A new `MD_MULT` issued right after release completes normally.
- Back-to-back `MD_MULT` with `start` in the first non-busy cycle: `MD_MFLO` in that same cycle gives `mdRes` equal to the first product's low word, and the second product lands 5 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// default execution latencies and the sequencer state type.
package mdu_pkg;

    // Operation codes presented on mdOp (MD_NONE must stay zero).
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    // Default execution latencies in clock cycles.
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Sequencer state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage. The result is computed in one
// combinational block at the start edge and held in hi_next/lo_next while
// a counter models the multi-cycle latency; HI/LO update on the last edge.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOp,
    input  logic        start,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdRes
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      hi_next_r;
    logic [31:0]      lo_next_r;

    logic [63:0]      prod_s;
    logic [31:0]      a_mag_s;
    logic [31:0]      b_mag_s;
    logic [31:0]      uquot_s;
    logic [31:0]      urem_s;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic             neg_q_s;
    logic             neg_r_s;
    logic             div0_s;

    // Product and quotient/remainder from the live operands; signed divide
    // works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    always_comb begin
        prod_s  = 64'd0;
        a_mag_s = srcA;
        b_mag_s = srcB;
        neg_q_s = 1'b0;
        neg_r_s = 1'b0;
        case (mdOp)
            MD_MULT: begin
                prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
            end
            MD_MULTU: begin
                prod_s = {32'd0, srcA} * {32'd0, srcB};
            end
            MD_DIV: begin
                a_mag_s = srcA[31] ? (32'd0 - srcA) : srcA;
                b_mag_s = srcB[31] ? (32'd0 - srcB) : srcB;
                neg_q_s = srcA[31] ^ srcB[31];
                neg_r_s = srcA[31];
            end
            default: begin
                prod_s = 64'd0;
            end
        endcase
        div0_s = (srcB == 32'd0);
        if (div0_s) begin
            uquot_s = 32'd0;
            urem_s  = 32'd0;
        end else begin
            uquot_s = a_mag_s / b_mag_s;
            urem_s  = a_mag_s % b_mag_s;
        end
        quot_s = neg_q_s ? (32'd0 - uquot_s) : uquot_s;
        rem_s  = neg_r_s ? (32'd0 - urem_s) : urem_s;
    end

    // Sequencer: accepts ops in IDLE, counts down in RUN, commits HI/LO on the last edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            hi_next_r <= 32'd0;
            lo_next_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (mdOp)
                            MD_MULT, MD_MULTU: begin
                                hi_next_r <= prod_s[63:32];
                                lo_next_r <= prod_s[31:0];
                                cnt_r     <= CNT_W'(MULT_CYCLES);
                                state_r   <= ST_RUN;
                                busy_r    <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                // A zero divisor commits the current HI/LO, i.e. leaves them unchanged.
                                if (div0_s) begin
                                    hi_next_r <= hi_r;
                                    lo_next_r <= lo_r;
                                end else begin
                                    hi_next_r <= rem_s;
                                    lo_next_r <= quot_s;
                                end
                                cnt_r   <= CNT_W'(DIV_CYCLES);
                                state_r <= ST_RUN;
                                busy_r  <= 1'b1;
                            end
                            MD_MTHI: begin
                                hi_r <= srcA;
                            end
                            MD_MTLO: begin
                                lo_r <= srcA;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        hi_r    <= hi_next_r;
                        lo_r    <= lo_next_r;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Read port for mfhi/mflo; zero for every other opcode.
    always_comb begin
        case (mdOp)
            MD_MFHI: mdRes = hi_r;
            MD_MFLO: mdRes = lo_r;
            default: mdRes = 32'd0;
        endcase
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency, results, divide-by-zero,
// ignored mid-run starts, reset abort and back-to-back issue.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  mdOp;
    logic        start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdRes;

    int vec_cnt;
    int miss_cnt;
    int n;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .mdOp  (mdOp),
        .start (start),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .mdRes (mdRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start strobe; operands are scrambled afterwards to prove capture.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        mdOp  = MD_NONE;
        srcA  = 32'hDEADBEEF;
        srcB  = 32'h0BADF00D;
    endtask

    // Counts remaining busy cycles, bounded.
    task automatic run_len(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] op, input logic [31:0] exp);
        mdOp = op;
        #1;
        chk(tag, mdRes, exp);
        mdOp = MD_NONE;
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        reset = 1'b0;
        start = 1'b0;
        mdOp  = MD_NONE;
        srcA  = 32'd0;
        srcB  = 32'd0;
        tick();
        tick();
        reset = 1'b1;

        // Arbitrary activity, then two reset cycles.
        issue(MD_MTLO, 32'h00000055, 32'd0);
        issue(MD_MTHI, 32'h00000066, 32'd0);
        issue(MD_MULT, 32'd9, 32'd9);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_busy_after", {31'd0, busy}, 32'd0);
        chk("rst_lo_after", lo, 32'd0);

        // Signed multiply -2 * 3.
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
        run_len(n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        rd("mfhi", MD_MFHI, 32'hFFFFFFFF);
        rd("mflo", MD_MFLO, 32'hFFFFFFFA);
        rd("mdres_none", MD_NONE, 32'd0);

        // Unsigned multiply of the same operands.
        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
        run_len(n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // Signed divide -7 / 2.
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        run_len(n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // Divide by zero leaves HI/LO untouched.
        issue(MD_DIVU, 32'd7, 32'd0);
        chk("div0_busy", {31'd0, busy}, 32'd1);
        run_len(n);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_lo", lo, 32'hFFFFFFFD);
        chk("div0_hi", hi, 32'hFFFFFFFF);

        // mthi in IDLE.
        issue(MD_MTHI, 32'h12345678, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

        // mthi/mtlo during RUN are ignored; pending product lands.
        issue(MD_MULT, 32'd6, 32'd7);
        mdOp  = MD_MTHI;
        srcA  = 32'hAAAAAAAA;
        start = 1'b1;
        tick();
        mdOp  = MD_MTLO;
        tick();
        start = 1'b0;
        mdOp  = MD_NONE;
        chk("ign_hi_mid", hi, 32'h12345678);
        run_len(n);
        chk("ign_cycles", 32'(n), 32'd3);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);

        // Signed overflow case and positive/negative divide.
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_len(n);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
        run_len(n);
        chk("div_pn_lo", lo, 32'hFFFFFFFD);
        chk("div_pn_hi", hi, 32'd1);
        issue(MD_DIVU, 32'hFFFFFFF9, 32'd2);
        run_len(n);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        chk("divu_hi", hi, 32'd1);

        // Reset at cycle 3 of a divide aborts it.
        issue(MD_DIV, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        reset = 1'b1;
        issue(MD_MULT, 32'h00010000, 32'h00010000);
        run_len(n);
        chk("post_rst_cycles", 32'(n), 32'd5);
        chk("post_rst_hi", hi, 32'd1);
        chk("post_rst_lo", lo, 32'd0);
        tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_hold", hi, 32'd1);

        // Back-to-back multiply with zero idle gap.
        issue(MD_MULT, 32'd5, 32'd5);
        run_len(n);
        chk("b2b1_cycles", 32'(n), 32'd5);
        rd("b2b_mflo", MD_MFLO, 32'd25);
        issue(MD_MULT, 32'd3, 32'hFFFFFFFC);
        chk("b2b2_busy", {31'd0, busy}, 32'd1);
        run_len(n);
        chk("b2b2_cycles", 32'(n), 32'd5);
        chk("b2b2_hi", hi, 32'hFFFFFFFF);
        chk("b2b2_lo", lo, 32'hFFFFFFF4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    // Watchdog against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
